// File: rtl/mac_lane_array.sv
`default_nettype none
// ============================================================================
// mac_lane_array : multi-lane signed fixed-point MAC, 2-stage valid/ready pipe
// Revision: 1.0
// ============================================================================
module mac_lane_array #(
  parameter int LANES = 4,
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int ACC_W = 40
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             mode,
  input  logic [LANES*IN_W-1:0]  mx,
  input  logic [LANES*IN_W-1:0]  my,
  input  logic [LANES*OUT_W-1:0] az,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] mac,
  output logic [LANES-1:0]       sat_flag
);

  localparam int c_prod_w = 2 * IN_W;

  localparam logic [1:0] c_mode_madd    = 2'b00;
  localparam logic [1:0] c_mode_acc     = 2'b01;
  localparam logic [1:0] c_mode_restart = 2'b10;
  localparam logic [1:0] c_mode_drain   = 2'b11;

  // Clamp bounds expressed one bit wider than the accumulator so that sums
  // of two in-range values can be compared without overflow.
  localparam logic signed [ACC_W:0] c_out_max =
    {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] c_out_min =
    {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [ACC_W:0] c_acc_max = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] c_acc_min = {2'b11, {(ACC_W-1){1'b0}}};

  if (ACC_W < 2*IN_W || ACC_W < OUT_W) begin : g_param_check
    $error("mac_lane_array: ACC_W must be >= 2*IN_W and >= OUT_W");
  end

  logic       w_advance;
  logic       w_accept;
  logic       r_s1_valid;
  logic [1:0] r_s1_mode;
  logic       r_out_valid;

  assign w_advance = !r_out_valid || out_ready;
  assign w_accept  = in_valid && w_advance;
  assign in_ready  = w_advance;
  assign out_valid = r_out_valid;

  // Shared control: S1 is refilled (or emptied) whenever the pipe advances.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1_valid  <= 1'b0;
      r_s1_mode   <= c_mode_madd;
      r_out_valid <= 1'b0;
    end else if (w_advance) begin
      r_s1_valid  <= w_accept;
      r_out_valid <= r_s1_valid;
      if (w_accept) begin
        r_s1_mode <= mode;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [IN_W-1:0]     w_mx;
    logic signed [IN_W-1:0]     w_my;
    logic signed [c_prod_w-1:0] w_prod;
    logic signed [c_prod_w-1:0] r_prod;
    logic signed [OUT_W-1:0]    r_az;
    logic signed [ACC_W-1:0]    r_acc;
    logic signed [OUT_W-1:0]    r_mac;
    logic                       r_sat;

    logic signed [ACC_W:0]      w_p_ext;
    logic signed [ACC_W:0]      w_az_ext;
    logic signed [ACC_W:0]      w_acc_ext;
    logic signed [ACC_W:0]      w_acc_sum;
    logic signed [ACC_W:0]      w_pre;
    logic signed [ACC_W-1:0]    w_acc_sat;
    logic signed [ACC_W-1:0]    w_acc_next;
    logic signed [OUT_W-1:0]    w_mac_next;
    logic                       w_clip;

    assign w_mx   = mx[i*IN_W +: IN_W];
    assign w_my   = my[i*IN_W +: IN_W];
    assign w_prod = w_mx * w_my;

    always_ff @(posedge CLK) begin
      if (RST) begin
        r_prod <= '0;
        r_az   <= '0;
      end else if (w_accept) begin
        r_prod <= w_prod;
        r_az   <= az[i*OUT_W +: OUT_W];
      end
    end

    assign w_p_ext   = {{(ACC_W+1-c_prod_w){r_prod[c_prod_w-1]}}, r_prod};
    assign w_az_ext  = {{(ACC_W+1-OUT_W){r_az[OUT_W-1]}}, r_az};
    assign w_acc_ext = {r_acc[ACC_W-1], r_acc};
    assign w_acc_sum = w_acc_ext + w_p_ext;

    always_comb begin
      w_acc_sat  = w_acc_sum[ACC_W-1:0];
      w_acc_next = r_acc;
      w_pre      = w_acc_ext;
      w_mac_next = '0;
      w_clip     = 1'b0;

      if (w_acc_sum > c_acc_max) begin
        w_acc_sat = c_acc_max[ACC_W-1:0];
      end else if (w_acc_sum < c_acc_min) begin
        w_acc_sat = c_acc_min[ACC_W-1:0];
      end

      case (r_s1_mode)
        c_mode_madd: begin
          w_pre      = w_p_ext + w_az_ext;
          w_acc_next = r_acc;
        end
        c_mode_acc: begin
          w_pre      = {w_acc_sat[ACC_W-1], w_acc_sat};
          w_acc_next = w_acc_sat;
        end
        c_mode_restart: begin
          w_pre      = w_p_ext;
          w_acc_next = w_p_ext[ACC_W-1:0];
        end
        default: begin
          w_pre      = w_acc_ext;
          w_acc_next = '0;
        end
      endcase

      if (w_pre > c_out_max) begin
        w_mac_next = c_out_max[OUT_W-1:0];
        w_clip     = 1'b1;
      end else if (w_pre < c_out_min) begin
        w_mac_next = c_out_min[OUT_W-1:0];
        w_clip     = 1'b1;
      end else begin
        w_mac_next = w_pre[OUT_W-1:0];
      end
    end

    // The accumulator only moves together with its beat entering S2.
    always_ff @(posedge CLK) begin
      if (RST) begin
        r_acc <= '0;
        r_mac <= '0;
        r_sat <= 1'b0;
      end else if (w_advance && r_s1_valid) begin
        r_acc <= w_acc_next;
        r_mac <= w_mac_next;
        r_sat <= w_clip;
      end
    end

    assign mac[i*OUT_W +: OUT_W] = r_mac;
    assign sat_flag[i]           = r_sat;
  end

endmodule
`default_nettype wire

// File: doc/mac_lane_array.md
Name: mac_lane_array

Overview:
Parametrised multi-lane signed fixed-point multiply-accumulate engine. It is the next generation of the single-lane mac_top core.
- LANES independent lanes share one control stream carried by a valid/ready handshake.
- Each beat selects a per-beat mode: single-shot MAC with addend, accumulate, restart-accumulate, or drain.
- Sits behind the user-project wrapper: operands come from LA/Wishbone staging registers, results go back to LA outputs.

Parameters:
LANES, 4, number of parallel MAC lanes
IN_W, 16, signed operand width (mx, my)
OUT_W, 32, signed addend/result width (az, mac)
ACC_W, 40, signed internal accumulator width; must be >= 2*IN_W and >= OUT_W

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  synchronous reset, active-high
in_valid  input  1  input beat present
in_ready  output  1  engine can accept a beat this cycle
mode  input  2  beat mode: 00 MADD, 01 ACC, 10 RESTART, 11 DRAIN
mx  input  LANES*IN_W  multiplicands; lane i at [i*IN_W +: IN_W]
my  input  LANES*IN_W  multipliers, same packing
az  input  LANES*OUT_W  addends, used in MADD only
out_valid  output  1  result beat present
out_ready  input  1  consumer accepts result
mac  output  LANES*OUT_W  results, lane i at [i*OUT_W +: OUT_W]
sat_flag  output  LANES  lane i result was clipped to OUT_W

Behaviour:
- Reset (RST=1 at a clock edge):
  - out_valid=0, mac=0, sat_flag=0.
  - All accumulators=0, S1 valid=0.
  - in_ready=1 in the cycle after reset.
  - Reset mid-operation discards in-flight beats with no output.
- Pipeline and flow control:
  - Two stages: S1 registers mode and per-lane signed product mx*my (2*IN_W bits) plus az. S2 is the output register.
  - advance = !out_valid | out_ready; in_ready = advance.
  - Input beat accepted when in_valid & in_ready; S1 loads only then.
  - S2 loads from S1 when advance; out_valid follows S1 valid.
  - When out_valid & !out_ready: mac, sat_flag and out_valid held stable, no beat lost or duplicated.
- Latency and throughput:
  - Accepted beat appears on out_valid exactly 2 cycles later absent backpressure.
  - Throughput is 1 beat/cycle.
- Per-lane arithmetic at S2. Product p is sign-extended to ACC_W. sat() clamps an ACC_W value to the OUT_W signed range and sets sat_flag[i] when clipping occurs.
  - MADD: mac = sat(p + sext(az)); acc unchanged.
  - ACC: acc_n = satA(acc + p); acc <= acc_n; mac = sat(acc_n).
  - RESTART: acc <= p; mac = sat(p).
  - DRAIN: mac = sat(acc); acc <= 0; mx/my/az ignored.
  - satA clamps to the ACC_W signed range; accumulators never wrap.
- Back-to-back ACC beats use the accumulator value updated by the immediately preceding beat; no bubble or hazard.
- Accumulator updates only when the beat moves S1->S2, never while stalled.
- sat_flag is per-result, not sticky.
- Lanes are fully independent; one lane saturating does not affect others.

Test Plan:
- Reset: hold RST 2 cycles -> out_valid=0, mac=0, sat_flag=0, in_ready=1; DRAIN beat then outputs mac=0 in all lanes.
- MADD: all lanes mx=3, my=-5, az=100, out_ready=1 -> 2 cycles later out_valid=1, mac=85 per lane, sat_flag=0; az=-2147483648, mx=my=-1 -> mac=-2147483647.
- Accumulate stream:
  - Stimulus: RESTART mx=2,my=3, then 3 consecutive ACC beats mx=2,my=3.
  - Response: consecutive results 6,12,18,24.
  - Then DRAIN -> 24, and a subsequent ACC 1*1 -> 1.
- Saturation:
  - Stimulus: lane0 RESTART 32767*32767, then ACC same operands; lane1 fed 1*1.
  - Lane0 results: 1073676289, 2147352578, then 2147483647 with sat_flag[0]=1.
  - DRAIN after the 3rd beat -> 2147483647, sat_flag[0]=1; lane1 unaffected.
- Backpressure: continuous ACC 1*1 stream, out_ready=0 for 3 cycles mid-stream -> in_ready=0 during stall, mac held constant, resumed sequence strictly +1 per beat with no gaps or repeats.
- Reset mid-accumulation: after acc=18, assert RST one cycle with a beat in S1 -> out_valid=0 next cycle, in-flight beat dropped; then ACC 1*1 -> mac=1.
